fetch_ctrl: RTL and testbench
=============================

Name: fetch_ctrl

Overview:
Fetch-stage sequencer for the pipeline front end. It owns the fetch PC and drives a request/response handshake to instruction memory, with one request outstanding at a time. It loads the IF/ID pipeline register and honours stall from ID and redirect/flush from later stages. It replaces the free-running PC→imem→IF/ID path in cpu_top.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, fetch address after reset
NOP_INSTR, 32'h0000_0013, instruction (addi x0,x0,0) placed in IF/ID on bubble/flush

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  synchronous, active-high reset
imem_req_valid  out  1  fetch request valid
imem_req_addr  out  XLEN  fetch address (word aligned)
imem_req_ready  in  1  memory accepts request this cycle
imem_rsp_valid  in  1  instruction returned this cycle
imem_rsp_instr  in  32  returned instruction
stall_id  in  1  ID cannot accept; hold IF/ID
redirect_valid  in  1  taken branch/jump: flush and refetch
redirect_pc  in  XLEN  redirect target
ifid_valid  out  1  IF/ID holds a real instruction
ifid_instr  out  32  IF/ID instruction
ifid_pc  out  XLEN  PC of ifid_instr
ifid_pc4  out  XLEN  ifid_pc + 4
fetch_pc  out  XLEN  current fetch PC
instr_count  out  32  count of instructions delivered to IF/ID

Behaviour:
- Reset (synchronous, active-high). Applies in any state, including with a request outstanding. Results: state=REQ, fetch_pc=RESET_PC, ifid_valid=0, ifid_instr=NOP_INSTR, ifid_pc=0, ifid_pc4=0, instr_count=0, discard=0, buffer empty. In the reset cycle imem_req_valid=0. imem_req_valid rises in the first cycle after reset deasserts.
- States:
  - REQ: imem_req_valid=1, imem_req_addr=fetch_pc. On imem_req_ready, go to WAIT.
  - WAIT: request outstanding, imem_req_valid=0.
  - HOLD: a response is buffered while ID is stalled, imem_req_valid=0.
- imem_rsp_valid outside WAIT is ignored. This covers a stale response arriving after reset.
- WAIT on imem_rsp_valid:
  - If discard=1: drop the response, clear discard, go to REQ.
  - Else if the IF/ID slot is free (ifid_valid=0 or stall_id=0): load IF/ID with instr=rsp, pc=fetch_pc, pc4=fetch_pc+4, valid=1. Then fetch_pc += 4, instr_count += 1, go to REQ.
  - Else: capture instr/pc into the one-entry buffer, go to HOLD.
- HOLD: when stall_id=0, move the buffer into IF/ID, fetch_pc += 4, instr_count += 1, go to REQ.
- IF/ID hold/bubble rules:
  - stall_id=1 with ifid_valid=1: IF/ID holds every field unchanged.
  - stall_id=0 with no delivery this cycle: ifid_valid←0, ifid_instr←NOP_INSTR.
- Redirect has highest priority after reset. Any state with redirect_valid=1:
  - fetch_pc←{redirect_pc[XLEN-1:2],2'b00}.
  - IF/ID flushed (valid=0, NOP_INSTR), regardless of stall_id.
  - Buffer cleared, no instr_count increment.
  - Next state:
    - REQ without ready: stay REQ; the new address appears next cycle.
    - REQ with ready that same cycle: old-address request is accepted; go to WAIT with discard=1.
    - WAIT, rsp_valid=0: stay WAIT with discard=1.
    - WAIT, rsp_valid=1: drop the response, go to REQ.
    - HOLD: go to REQ.
- A second redirect while discard=1 only updates fetch_pc; discard stays 1.
- Arithmetic:
  - fetch_pc and pc4 wrap modulo 2^XLEN (0xFFFF_FFFC+4 = 0).
  - instr_count wraps at 2^32.
- Latency/throughput: with ready=1 and the response one cycle after accept, an instruction reaches IF/ID two cycles after REQ. Throughput is 1 instruction per 2 cycles. Combinational ready→valid paths are forbidden except imem_req_valid/addr decoded from state and fetch_pc.

Decomposition:
- Shared package cpu_pkg holds: XLEN, RESET_PC default, NOP_INSTR, and the fetch state encoding (REQ, WAIT, HOLD).
- One natural sub-module: fetch_skid_buf, a one-entry instr/pc holding register with load/clear/valid.
- FSM, PC, IF/ID register and counter stay in fetch_ctrl.

Test Plan:
- Reset, then ready=1 and response one cycle after each accept → request addresses 0x0, 0x4, 0x8. ifid_pc4 = 0x4, 0x8, 0xC; ifid_valid pulses in IF/ID load cycles; instr_count=3.
- stall_id=1 with ifid_valid=1, then response 0xDEADBEEF arrives → state HOLD, no request, IF/ID unchanged. Release stall after 3 cycles → ifid_instr=0xDEADBEEF next cycle, then request at next PC.
- redirect_valid with redirect_pc=0x100 while in WAIT; response arrives 2 cycles later → response dropped, ifid_valid=0, next imem_req_addr=0x100, instr_count unchanged.
- redirect_pc=0x103 in the same cycle as imem_rsp_valid in WAIT → response dropped, next request addr 0x100, no discard left pending.
- RESET_PC=0xFFFF_FFFC, one fetch → ifid_pc4=0x0, next request addr 0x0.
- Assert reset in WAIT, then imem_rsp_valid arrives the cycle after reset release → ignored. ifid_valid=0, request at RESET_PC, instr_count=0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared front-end definitions: datapath width, reset fetch address, bubble
// instruction and the fetch sequencer state encoding.
package cpu_pkg;

   localparam int unsigned XLEN      = 32;
   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [1:0] {
      ST_REQ  = 2'd0,
      ST_WAIT = 2'd1,
      ST_HOLD = 2'd2
   } fetch_state_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry instruction/PC holding register. Parks a fetched instruction
// while ID is stalled so the request channel can stay idle.
module fetch_skid_buf #(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load,
   input  logic            clear,
   input  logic [31:0]     load_instr,
   input  logic [XLEN-1:0] load_pc,
   output logic            valid,
   output logic [31:0]     instr,
   output logic [XLEN-1:0] pc
);

   // Clear wins over load so a redirect always empties the entry.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         valid <= 1'b0;
         instr <= '0;
         pc    <= '0;
      end else if (load) begin
         valid <= 1'b1;
         instr <= load_instr;
         pc    <= load_pc;
      end
   end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch-stage sequencer: owns the fetch PC, runs a single-outstanding
// request/response handshake to imem and loads the IF/ID register.
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_REQ  | request valid at fetch_pc, waiting for imem_req_ready
// ST_WAIT | request accepted, waiting for imem_rsp_valid
// ST_HOLD | response parked in the skid buffer while ID is stalled
module fetch_ctrl #(
   parameter int unsigned     XLEN      = cpu_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC  = XLEN'(cpu_pkg::RESET_PC),
   parameter logic [31:0]     NOP_INSTR = cpu_pkg::NOP_INSTR
) (
   input  logic            clk,
   input  logic            reset,
   output logic            imem_req_valid,
   output logic [XLEN-1:0] imem_req_addr,
   input  logic            imem_req_ready,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rsp_instr,
   input  logic            stall_id,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            ifid_valid,
   output logic [31:0]     ifid_instr,
   output logic [XLEN-1:0] ifid_pc,
   output logic [XLEN-1:0] ifid_pc4,
   output logic [XLEN-1:0] fetch_pc,
   output logic [31:0]     instr_count
);
   import cpu_pkg::*;

   fetch_state_t    state, state_nx;
   logic            discard, discard_nx;
   logic [XLEN-1:0] pc_nx;
   logic            deliver;
   logic [31:0]     dl_instr;
   logic [XLEN-1:0] dl_pc;
   logic            flush;
   logic            buf_load, buf_clear, buf_valid;
   logic [31:0]     buf_instr;
   logic [XLEN-1:0] buf_pc;
   logic            slot_free;
   logic            unused_redirect_lsb;

   assign unused_redirect_lsb = ^redirect_pc[1:0];

   fetch_skid_buf #(.XLEN(XLEN)) u_skid (
      .clk        (clk),
      .reset      (reset),
      .load       (buf_load),
      .clear      (buf_clear),
      .load_instr (imem_rsp_instr),
      .load_pc    (fetch_pc),
      .valid      (buf_valid),
      .instr      (buf_instr),
      .pc         (buf_pc)
   );

   // Request outputs decode from state and fetch_pc only; gated off while in reset.
   assign imem_req_valid = (state == ST_REQ) && !reset;
   assign imem_req_addr  = fetch_pc;
   assign slot_free      = !ifid_valid || !stall_id;

   always_comb begin
      state_nx   = state;
      discard_nx = discard;
      pc_nx      = fetch_pc;
      deliver    = 1'b0;
      dl_instr   = imem_rsp_instr;
      dl_pc      = fetch_pc;
      flush      = 1'b0;
      buf_load   = 1'b0;
      buf_clear  = 1'b0;
      if (redirect_valid) begin
         flush     = 1'b1;
         buf_clear = 1'b1;
         pc_nx     = {redirect_pc[XLEN-1:2], 2'b00};
         unique case (state)
            ST_REQ: begin
               // An old-address request accepted this cycle must be thrown away later.
               if (imem_req_ready) begin
                  state_nx   = ST_WAIT;
                  discard_nx = 1'b1;
               end
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  state_nx   = ST_REQ;
                  discard_nx = 1'b0;
               end else begin
                  discard_nx = 1'b1;
               end
            end
            default: state_nx = ST_REQ;
         endcase
      end else begin
         unique case (state)
            ST_REQ: begin
               if (imem_req_ready) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
               if (imem_rsp_valid) begin
                  if (discard) begin
                     discard_nx = 1'b0;
                     state_nx   = ST_REQ;
                  end else if (slot_free) begin
                     deliver  = 1'b1;
                     pc_nx    = fetch_pc + XLEN'(4);
                     state_nx = ST_REQ;
                  end else begin
                     buf_load = 1'b1;
                     state_nx = ST_HOLD;
                  end
               end
            end
            ST_HOLD: begin
               if (!stall_id && buf_valid) begin
                  deliver   = 1'b1;
                  dl_instr  = buf_instr;
                  dl_pc     = buf_pc;
                  buf_clear = 1'b1;
                  pc_nx     = fetch_pc + XLEN'(4);
                  state_nx  = ST_REQ;
               end
            end
            default: state_nx = ST_REQ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_REQ;
         discard     <= 1'b0;
         fetch_pc    <= RESET_PC;
         ifid_valid  <= 1'b0;
         ifid_instr  <= NOP_INSTR;
         ifid_pc     <= '0;
         ifid_pc4    <= '0;
         instr_count <= '0;
      end else begin
         state    <= state_nx;
         discard  <= discard_nx;
         fetch_pc <= pc_nx;
         if (flush) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
         end else if (deliver) begin
            ifid_valid <= 1'b1;
            ifid_instr <= dl_instr;
            ifid_pc    <= dl_pc;
            ifid_pc4   <= dl_pc + XLEN'(4);
         end else if (!stall_id) begin
            ifid_valid <= 1'b0;
            ifid_instr <= NOP_INSTR;
         end
         if (deliver) instr_count <= instr_count + 32'd1;
      end
   end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: two instances (RESET_PC 0 and 0xFFFF_FFFC)
// share stimulus and are checked every cycle against a behavioural model.
module tb_fetch_ctrl;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ready = 1'b0, rsp_v = 1'b0, stall = 1'b0, redir = 1'b0;
   logic [31:0] rsp_i = '0, rpc = '0;

   logic        d_rv [2];
   logic [31:0] d_ra [2];
   logic        d_iv [2];
   logic [31:0] d_ii [2], d_ip [2], d_ip4 [2], d_fp [2], d_cnt [2];

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fetch_ctrl #(.RESET_PC(32'h0000_0000)) u0 (
      .clk(clk), .reset(reset),
      .imem_req_valid(d_rv[0]), .imem_req_addr(d_ra[0]), .imem_req_ready(ready),
      .imem_rsp_valid(rsp_v), .imem_rsp_instr(rsp_i), .stall_id(stall),
      .redirect_valid(redir), .redirect_pc(rpc),
      .ifid_valid(d_iv[0]), .ifid_instr(d_ii[0]), .ifid_pc(d_ip[0]), .ifid_pc4(d_ip4[0]),
      .fetch_pc(d_fp[0]), .instr_count(d_cnt[0])
   );

   fetch_ctrl #(.RESET_PC(32'hFFFF_FFFC)) u1 (
      .clk(clk), .reset(reset),
      .imem_req_valid(d_rv[1]), .imem_req_addr(d_ra[1]), .imem_req_ready(ready),
      .imem_rsp_valid(rsp_v), .imem_rsp_instr(rsp_i), .stall_id(stall),
      .redirect_valid(redir), .redirect_pc(rpc),
      .ifid_valid(d_iv[1]), .ifid_instr(d_ii[1]), .ifid_pc(d_ip[1]), .ifid_pc4(d_ip4[1]),
      .fetch_pc(d_fp[1]), .instr_count(d_cnt[1])
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: outstanding request flag, one parked response, pending discard.
   logic [31:0] m_pc [2], m_ii [2], m_ip [2], m_ip4 [2], m_cnt [2], m_hi [2];
   bit          m_out [2], m_held [2], m_disc [2], m_iv [2];
   bit          m_live = 0;
   bit          m_got;
   logic [31:0] m_gi;

   function automatic logic [31:0] base_pc(input int k);
      return (k == 0) ? 32'h0000_0000 : 32'hFFFF_FFFC;
   endfunction

   always @(posedge clk) begin
      if (reset) m_live = 1;
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_pc[k] = base_pc(k); m_out[k] = 0; m_held[k] = 0; m_disc[k] = 0;
            m_iv[k] = 0; m_ii[k] = NOP; m_ip[k] = 0; m_ip4[k] = 0; m_cnt[k] = 0;
         end else if (redir) begin
            m_pc[k] = rpc & ~32'h3;
            m_iv[k] = 0;
            m_ii[k] = NOP;
            if (m_held[k]) m_held[k] = 0;
            else if (!m_out[k]) begin
               if (ready) begin m_out[k] = 1; m_disc[k] = 1; end
            end else if (rsp_v) begin
               m_out[k] = 0; m_disc[k] = 0;
            end else m_disc[k] = 1;
         end else begin
            m_got = 0;
            m_gi  = '0;
            if (!m_out[k] && !m_held[k]) begin
               if (ready) m_out[k] = 1;
            end else if (m_out[k]) begin
               if (rsp_v) begin
                  m_out[k] = 0;
                  if (m_disc[k]) m_disc[k] = 0;
                  else if (!m_iv[k] || !stall) begin m_got = 1; m_gi = rsp_i; end
                  else begin m_held[k] = 1; m_hi[k] = rsp_i; end
               end
            end else if (!stall) begin
               m_held[k] = 0; m_got = 1; m_gi = m_hi[k];
            end
            if (m_got) begin
               m_iv[k] = 1; m_ii[k] = m_gi; m_ip[k] = m_pc[k];
               m_ip4[k] = m_pc[k] + 32'd4; m_pc[k] = m_pc[k] + 32'd4;
               m_cnt[k] = m_cnt[k] + 32'd1;
            end else if (!stall) begin
               m_iv[k] = 0; m_ii[k] = NOP;
            end
         end
      end
   end

   always @(negedge clk) begin
      if (m_live) begin
         for (int k = 0; k < 2; k++) begin
            chk($sformatf("u%0d.req_valid", k), 32'(d_rv[k]),
                32'(!reset && !m_out[k] && !m_held[k]));
            if (!reset && !m_out[k] && !m_held[k])
               chk($sformatf("u%0d.req_addr", k), d_ra[k], m_pc[k]);
            chk($sformatf("u%0d.ifid_valid", k), 32'(d_iv[k]), 32'(m_iv[k]));
            chk($sformatf("u%0d.ifid_instr", k), d_ii[k], m_ii[k]);
            chk($sformatf("u%0d.ifid_pc", k), d_ip[k], m_ip[k]);
            chk($sformatf("u%0d.ifid_pc4", k), d_ip4[k], m_ip4[k]);
            chk($sformatf("u%0d.fetch_pc", k), d_fp[k], m_pc[k]);
            chk($sformatf("u%0d.instr_count", k), d_cnt[k], m_cnt[k]);
         end
      end
   end

   task automatic cyc(input bit rd, input bit rv, input logic [31:0] ri,
                      input bit st, input bit rdr, input logic [31:0] rp);
      ready = rd; rsp_v = rv; rsp_i = ri; stall = st; redir = rdr; rpc = rp;
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_one(input logic [31:0] instr);
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, instr, 0, 0, 0);
   endtask

   initial begin
      reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst.req_valid", 32'(d_rv[0]), 32'd0);
      chk("rst.ifid_instr", d_ii[0], NOP);
      chk("rst.fetch_pc_u1", d_fp[1], 32'hFFFF_FFFC);
      reset = 1'b0;
      #1;
      chk("post_rst.req_valid", 32'(d_rv[0]), 32'd1);

      // Sequential fetches, one instruction per two cycles.
      fetch_one(32'hA000_0000);
      chk("f0.ifid_valid", 32'(d_iv[0]), 32'd1);
      chk("f0.ifid_pc4", d_ip4[0], 32'h4);
      chk("wrap.ifid_pc", d_ip[1], 32'hFFFF_FFFC);
      chk("wrap.ifid_pc4", d_ip4[1], 32'h0);
      chk("wrap.req_addr", d_ra[1], 32'h0);
      fetch_one(32'hA000_0001);
      chk("f1.ifid_pc4", d_ip4[0], 32'h8);
      fetch_one(32'hA000_0002);
      chk("f2.ifid_pc4", d_ip4[0], 32'hC);
      chk("f2.count", d_cnt[0], 32'd3);
      chk("f2.req_addr", d_ra[0], 32'hC);

      // Response lands while ID is stalled: parked in HOLD.
      cyc(1, 0, 0, 1, 0, 0);
      cyc(0, 1, 32'hDEAD_BEEF, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      cyc(0, 0, 0, 1, 0, 0);
      chk("hold.req_valid", 32'(d_rv[0]), 32'd0);
      chk("hold.ifid_instr", d_ii[0], 32'hA000_0002);
      cyc(0, 0, 0, 0, 0, 0);
      chk("unstall.ifid_instr", d_ii[0], 32'hDEAD_BEEF);
      chk("unstall.ifid_pc", d_ip[0], 32'hC);
      chk("unstall.req_addr", d_ra[0], 32'h10);
      chk("unstall.count", d_cnt[0], 32'd4);

      // Redirect while waiting; late response must be dropped.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 1, 32'h100);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 1, 32'h0BAD_0001, 0, 0, 0);
      chk("rdw.ifid_valid", 32'(d_iv[0]), 32'd0);
      chk("rdw.req_addr", d_ra[0], 32'h100);
      chk("rdw.count", d_cnt[0], 32'd4);

      // Redirect coinciding with the response, unaligned target.
      cyc(1, 0, 0, 0, 0, 0);
      cyc(0, 1, 32'h0BAD_0002, 0, 1, 32'h103);
      chk("rdr.req_valid", 32'(d_rv[0]), 32'd1);
      chk("rdr.req_addr", d_ra[0], 32'h100);
      fetch_one(32'h0000_1234);
      chk("rdr.ifid_instr", d_ii[0], 32'h0000_1234);
      chk("rdr.ifid_pc", d_ip[0], 32'h100);
      chk("rdr.count", d_cnt[0], 32'd5);

      // Redirect on an accepting REQ cycle, then a second redirect while discarding.
      cyc(1, 0, 0, 0, 1, 32'h200);
      cyc(0, 0, 0, 0, 1, 32'h300);
      cyc(0, 1, 32'h0BAD_0003, 0, 0, 0);
      chk("rdq.req_addr", d_ra[0], 32'h300);
      chk("rdq.count", d_cnt[0], 32'd5);
      fetch_one(32'h0000_5678);
      chk("rdq.ifid_pc", d_ip[0], 32'h300);

      // Reset with a request outstanding; stale response afterwards is ignored.
      cyc(1, 0, 0, 0, 0, 0);
      reset = 1'b1;
      cyc(0, 0, 0, 0, 0, 0);
      reset = 1'b0;
      cyc(0, 1, 32'h5555_5555, 0, 0, 0);
      chk("stale.ifid_valid", 32'(d_iv[0]), 32'd0);
      chk("stale.req_valid", 32'(d_rv[0]), 32'd1);
      chk("stale.req_addr", d_ra[0], 32'h0);
      chk("stale.count", d_cnt[0], 32'd0);
      chk("stale.req_addr_u1", d_ra[1], 32'hFFFF_FFFC);

      fetch_one(32'h0000_0777);
      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
